// File: rtl/multdiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
// The divide datapath is present only when MULTDIV_DIVIDE_EN is defined.
package multdiv_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ABS_A = 3'd1;
    localparam logic [2:0] ST_ABS_B = 3'd2;
    localparam logic [2:0] ST_ITER  = 3'd3;
    localparam logic [2:0] ST_FIX   = 3'd4;

    localparam int ITER_COUNT      = 32;
    localparam int MULTDIV_LATENCY = 35;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // Product magnitude {hi, lo} must fit a signed 32-bit result of the given sign.
    function automatic logic mul_overflow(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic neg);
        mul_overflow = (hi != 32'h0000_0000)
                     | (~neg & lo[31])
                     | (neg & lo[31] & (lo[30:0] != 31'h0000_0000));
    endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Start/operand/result bundle between the execute stage and the multiply/divide unit.
interface multdiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_sequencer_adder.sv
// Team 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carry.
module thirtytwobitadder (
    output logic [31:0] S,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Cout,
    input  logic        cin
);

    logic [31:0] w_g;
    logic [31:0] w_p;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Carries inside each group come straight from generate/propagate and the group carry-in.
    always_comb begin : p_cla
        logic [32:0] w_c;
        w_c    = 33'd0;
        w_c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
        end
        S    = w_p ^ w_c[31:0];
        Cout = w_c[32];
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Signed 32-bit multiply/divide sequencer sharing one adder across all steps.
// Define MULTDIV_DIVIDE_EN to include the restoring-divide datapath.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    multdiv_sequencer_if.slave bus
);

    if (WIDTH != 32) begin : g_width_check
        $error("multdiv_sequencer: WIDTH must be 32 (shared adder is 32-bit)");
    end

    logic [2:0]            r_state;
    op_e                   r_op;
    logic                  r_sign;
    logic [WIDTH-1:0]      r_hi;
    logic [WIDTH-1:0]      r_lo;
    logic [WIDTH-1:0]      r_b;
    logic [ITER_COUNT-1:0] r_iter;
    logic [WIDTH-1:0]      r_result;
    logic                  r_exc;
    logic                  r_rdy;
    logic                  r_busy;

    logic [WIDTH-1:0]      w_add_a;
    logic [WIDTH-1:0]      w_add_b;
    logic                  w_cin;
    logic [WIDTH-1:0]      w_sum;
    logic                  w_cout;
    logic [WIDTH-1:0]      w_iter_hi;
    logic [WIDTH-1:0]      w_iter_lo;
    logic [WIDTH-1:0]      w_fix_result;
    logic                  w_fix_exc;
    logic                  w_neg;
    logic [WIDTH-1:0]      w_signed_mag;

`ifdef MULTDIV_DIVIDE_EN
    logic [WIDTH-1:0]      w_rem_sh;
    assign w_rem_sh = {r_hi[30:0], r_lo[31]};
`endif

    thirtytwobitadder u_adder (
        .S    (w_sum),
        .A    (w_add_a),
        .B    (w_add_b),
        .Cout (w_cout),
        .cin  (w_cin)
    );

    // Per-state operand mux for the shared adder.
    always_comb begin
        w_add_a = 32'h0000_0000;
        w_add_b = 32'h0000_0000;
        w_cin   = 1'b0;
        case (r_state)
            ST_ABS_A: begin
                w_add_a = ~r_lo;
                w_cin   = 1'b1;
            end
            ST_ABS_B: begin
                w_add_a = ~r_b;
                w_cin   = 1'b1;
            end
            ST_ITER: begin
`ifdef MULTDIV_DIVIDE_EN
                if (r_op == OP_DIV) begin
                    w_add_a = w_rem_sh;
                    w_add_b = ~r_b;
                    w_cin   = 1'b1;
                end else begin
                    w_add_a = r_hi;
                    w_add_b = r_lo[0] ? r_b : 32'h0000_0000;
                end
`else
                w_add_a = r_hi;
                w_add_b = r_lo[0] ? r_b : 32'h0000_0000;
`endif
            end
            ST_FIX: begin
                w_add_a = ~r_lo;
                w_cin   = 1'b1;
            end
            default: begin
                w_add_a = 32'h0000_0000;
            end
        endcase
    end

    // One iteration step: multiply shifts the carry into hi, divide keeps the difference on no-borrow.
    always_comb begin
`ifdef MULTDIV_DIVIDE_EN
        if (r_op == OP_DIV) begin
            if (w_cout) begin
                w_iter_hi = w_sum;
                w_iter_lo = {r_lo[30:0], 1'b1};
            end else begin
                w_iter_hi = w_rem_sh;
                w_iter_lo = {r_lo[30:0], 1'b0};
            end
        end else begin
            w_iter_hi = {w_cout, w_sum[31:1]};
            w_iter_lo = {w_sum[0], r_lo[31:1]};
        end
`else
        w_iter_hi = {w_cout, w_sum[31:1]};
        w_iter_lo = {w_sum[0], r_lo[31:1]};
`endif
    end

    assign w_neg        = r_sign & (r_lo != 32'h0000_0000);
    assign w_signed_mag = w_neg ? w_sum : r_lo;

    // Final result and exception; the magnitude sits in r_lo for both operations.
    always_comb begin
        if (r_op == OP_MUL) begin
            w_fix_result = w_signed_mag;
            w_fix_exc    = mul_overflow(r_hi, r_lo, r_sign);
        end else begin
`ifdef MULTDIV_DIVIDE_EN
            if (r_b == 32'h0000_0000) begin
                w_fix_result = 32'h0000_0000;
                w_fix_exc    = 1'b1;
            end else begin
                w_fix_result = w_signed_mag;
                w_fix_exc    = ~r_sign & (r_lo == 32'h8000_0000);
            end
`else
            w_fix_result = 32'h0000_0000;
            w_fix_exc    = 1'b1;
`endif
        end
    end

    // Sequencer FSM and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_MUL;
            r_sign   <= 1'b0;
            r_hi     <= 32'h0000_0000;
            r_lo     <= 32'h0000_0000;
            r_b      <= 32'h0000_0000;
            r_iter   <= 32'h0000_0000;
            r_result <= 32'h0000_0000;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.ctrl_MULT) begin
                        r_op    <= OP_MUL;
                        r_lo    <= bus.data_operandA;
                        r_b     <= bus.data_operandB;
                        r_hi    <= 32'h0000_0000;
                        r_sign  <= bus.data_operandA[31] ^ bus.data_operandB[31];
                        r_busy  <= 1'b1;
                        r_state <= ST_ABS_A;
                    end else if (bus.ctrl_DIV) begin
                        r_op   <= OP_DIV;
                        r_busy <= 1'b1;
`ifdef MULTDIV_DIVIDE_EN
                        r_lo    <= bus.data_operandA;
                        r_b     <= bus.data_operandB;
                        r_hi    <= 32'h0000_0000;
                        r_sign  <= bus.data_operandA[31] ^ bus.data_operandB[31];
                        r_state <= ST_ABS_A;
`else
                        // Hold one cycle in FIX so the refusal completes two cycles after start.
                        r_iter  <= 32'h0000_0001;
                        r_state <= ST_FIX;
`endif
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_ABS_A: begin
                    if (r_lo[31]) begin
                        r_lo <= w_sum;
                    end
                    r_state <= ST_ABS_B;
                end
                ST_ABS_B: begin
                    if (r_b[31]) begin
                        r_b <= w_sum;
                    end
                    r_iter  <= 32'h0000_0001;
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    r_hi   <= w_iter_hi;
                    r_lo   <= w_iter_lo;
                    r_iter <= {r_iter[ITER_COUNT-2:0], 1'b0};
                    if (r_iter[ITER_COUNT-1]) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (r_iter[0]) begin
                        r_iter <= 32'h0000_0000;
                    end else begin
                        r_result <= w_fix_result;
                        r_exc    <= w_fix_exc;
                        r_rdy    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = r_busy;

endmodule
